// File: rtl/demux_1_to_2_fifo_if.sv
// Handshake bundle for the 1-to-2 FIFO demux: one producer stream in, two consumer streams out.
interface demux_1_to_2_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] In_Data;
  logic             In_Sel;
  logic             In_Valid;
  logic             In_Ready;

  logic [WIDTH-1:0] Out0_Data;
  logic             Out0_Valid;
  logic             Out0_Ready;
  logic [CW-1:0]    Out0_Count;

  logic [WIDTH-1:0] Out1_Data;
  logic             Out1_Valid;
  logic             Out1_Ready;
  logic [CW-1:0]    Out1_Count;

  // master drives the producer side and consumes the outputs; slave is the demux itself
  modport master (
    output In_Data, In_Sel, In_Valid,
    input  In_Ready,
    input  Out0_Data, Out0_Valid, Out0_Count,
    input  Out1_Data, Out1_Valid, Out1_Count,
    output Out0_Ready, Out1_Ready
  );

  modport slave (
    input  In_Data, In_Sel, In_Valid,
    output In_Ready,
    output Out0_Data, Out0_Valid, Out0_Count,
    output Out1_Data, Out1_Valid, Out1_Count,
    input  Out0_Ready, Out1_Ready
  );
endinterface

// File: rtl/demux_1_to_2_fifo.sv
// Routes one word stream to one of two outputs by In_Sel; each output owns a small circular FIFO
// so a stalled consumer only blocks words headed for itself.
module demux_1_to_2_fifo_lane #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // full refuses even when popping in the same cycle: no pass-through path
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & valid_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok)
      rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // storage is cleared too so the outputs read zero straight after reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

module demux_1_to_2_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input logic                  Clk,
  input logic                  Reset,
  demux_1_to_2_fifo_if.slave   bus
);
  localparam int NUM_OUT = 2;

  logic [NUM_OUT-1:0]            push;
  logic [NUM_OUT-1:0]            pop;
  logic [NUM_OUT-1:0]            full;
  logic [NUM_OUT-1:0]            valid;
  logic [NUM_OUT-1:0]            ready;
  logic [NUM_OUT-1:0][WIDTH-1:0] data;
  logic [NUM_OUT-1:0][CW-1:0]    count;

  assign ready       = {bus.Out1_Ready, bus.Out0_Ready};
  assign bus.In_Ready = ~full[bus.In_Sel];

  generate
    for (genvar n = 0; n < NUM_OUT; n++) begin : g_out
      assign push[n] = bus.In_Valid & ~full[n] & (bus.In_Sel == 1'(n));
      assign pop[n]  = valid[n] & ready[n];

      demux_1_to_2_fifo_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .push_i  (push[n]),
        .data_i  (bus.In_Data),
        .pop_i   (pop[n]),
        .data_o  (data[n]),
        .valid_o (valid[n]),
        .full_o  (full[n]),
        .count_o (count[n])
      );
    end
  endgenerate

  assign bus.Out0_Data  = data[0];
  assign bus.Out0_Valid = valid[0];
  assign bus.Out0_Count = count[0];
  assign bus.Out1_Data  = data[1];
  assign bus.Out1_Valid = valid[1];
  assign bus.Out1_Count = count[1];
endmodule

// File: tb/tb_demux_1_to_2_fifo.sv
// Directed bench: stimulus pushes expected words into per-output queues, a negedge monitor
// pops and compares on every consumed word; directed checks cover counts, ready and reset.
module tb_demux_1_to_2_fifo;
  logic Clk = 1'b0;
  logic Reset = 1'b1;

  demux_1_to_2_fifo_if #(.WIDTH(32), .DEPTH(2)) bus ();

  demux_1_to_2_fifo #(.WIDTH(32), .DEPTH(2)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  logic        track_max = 1'b0;
  int unsigned max_cnt1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // offer a word until accepted or the budget runs out; expected value goes to the scoreboard
  task automatic push(input logic sel, input logic [31:0] d, input int budget);
    bit acc = 0;
    int n = 0;
    bus.In_Valid = 1'b1;
    bus.In_Sel   = sel;
    bus.In_Data  = d;
    while (!acc && n < budget) begin
      @(negedge Clk);
      if (bus.In_Ready === 1'b1) acc = 1;
      tick();
      n++;
    end
    bus.In_Valid = 1'b0;
    if (acc) begin
      if (sel) exp1.push_back(d);
      else     exp0.push_back(d);
    end else begin
      n_chk++;
      $display("FAIL accept 0x%08h: not accepted within %0d cycles (required accept)", d, budget);
    end
  endtask

  // monitor: every word consumed at the coming edge must match the queue head
  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus.Out0_Valid && bus.Out0_Ready) begin
        if (exp0.size() == 0) begin
          n_chk++;
          $display("FAIL out0 unexpected word 0x%08h (required none)", bus.Out0_Data);
        end else chk("out0 data", bus.Out0_Data, exp0.pop_front());
      end
      if (bus.Out1_Valid && bus.Out1_Ready) begin
        if (exp1.size() == 0) begin
          n_chk++;
          $display("FAIL out1 unexpected word 0x%08h (required none)", bus.Out1_Data);
        end else chk("out1 data", bus.Out1_Data, exp1.pop_front());
      end
      if (track_max && bus.Out1_Count > max_cnt1) max_cnt1 = bus.Out1_Count;
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, " out0 valid"}, 32'(bus.Out0_Valid), 32'd0);
    chk({tag, " out1 valid"}, 32'(bus.Out1_Valid), 32'd0);
    chk({tag, " out0 count"}, 32'(bus.Out0_Count), 32'd0);
    chk({tag, " out1 count"}, 32'(bus.Out1_Count), 32'd0);
    chk({tag, " out0 data"},  bus.Out0_Data, 32'd0);
    chk({tag, " out1 data"},  bus.Out1_Data, 32'd0);
    chk({tag, " in ready"},   32'(bus.In_Ready), 32'd1);
  endtask

  initial begin
    bus.In_Valid   = 1'b0;
    bus.In_Sel     = 1'b0;
    bus.In_Data    = '0;
    bus.Out0_Ready = 1'b0;
    bus.Out1_Ready = 1'b0;

    // reset and basic routing
    #12;
    check_reset_state("reset");
    tick();
    Reset = 1'b0;
    push(1'b0, 32'hAAAA0001, 4);
    push(1'b1, 32'hBBBB0002, 4);
    @(negedge Clk);
    chk("route out0 data",  bus.Out0_Data, 32'hAAAA0001);
    chk("route out1 data",  bus.Out1_Data, 32'hBBBB0002);
    chk("route out0 valid", 32'(bus.Out0_Valid), 32'd1);
    chk("route out1 valid", 32'(bus.Out1_Valid), 32'd1);
    chk("route out0 count", 32'(bus.Out0_Count), 32'd1);
    chk("route out1 count", 32'(bus.Out1_Count), 32'd1);
    tick();
    bus.Out0_Ready = 1'b1;
    bus.Out1_Ready = 1'b1;
    tick();
    bus.Out0_Ready = 1'b0;
    bus.Out1_Ready = 1'b0;

    // fill FIFO0, then check refuse and independence
    push(1'b0, 32'h10, 4);
    push(1'b0, 32'h11, 4);
    bus.In_Sel = 1'b0;
    @(negedge Clk);
    chk("fill out0 count", 32'(bus.Out0_Count), 32'd2);
    chk("full ready sel0", 32'(bus.In_Ready), 32'd0);
    bus.In_Sel = 1'b1;
    #1;
    chk("full ready sel1", 32'(bus.In_Ready), 32'd1);
    tick();
    push(1'b1, 32'h20, 4);
    @(negedge Clk);
    chk("indep out1 valid", 32'(bus.Out1_Valid), 32'd1);
    chk("indep out0 count", 32'(bus.Out0_Count), 32'd2);
    tick();

    // third word is held until one pop frees a slot
    fork
      push(1'b0, 32'h12, 10);
      begin
        tick();
        tick();
        @(negedge Clk);
        chk("held out0 count", 32'(bus.Out0_Count), 32'd2);
        tick();
        bus.Out0_Ready = 1'b1;
        tick();
        bus.Out0_Ready = 1'b0;
      end
    join
    @(negedge Clk);
    chk("refill out0 count", 32'(bus.Out0_Count), 32'd2);
    tick();
    bus.Out0_Ready = 1'b1;
    bus.Out1_Ready = 1'b1;
    repeat (3) tick();
    bus.Out0_Ready = 1'b0;
    bus.Out1_Ready = 1'b0;
    @(negedge Clk);
    chk("drain out0 count", 32'(bus.Out0_Count), 32'd0);
    chk("drain out1 count", 32'(bus.Out1_Count), 32'd0);
    tick();

    // streaming through output 1 with pointer wrap-around, one word per cycle
    bus.Out1_Ready = 1'b1;
    track_max = 1'b1;
    for (int i = 0; i < 8; i++) push(1'b1, 32'h30 + 32'(i), 1);
    tick();
    track_max = 1'b0;
    bus.Out1_Ready = 1'b0;
    chk("stream max count", 32'(max_cnt1), 32'd1);
    chk("stream drained", 32'(exp1.size()), 32'd0);

    // simultaneous push and pop on FIFO0
    push(1'b0, 32'h40, 4);
    @(negedge Clk);
    chk("sim pre count", 32'(bus.Out0_Count), 32'd1);
    chk("sim pre data",  bus.Out0_Data, 32'h40);
    tick();
    bus.Out0_Ready = 1'b1;
    push(1'b0, 32'h41, 1);
    bus.Out0_Ready = 1'b0;
    @(negedge Clk);
    chk("sim post count", 32'(bus.Out0_Count), 32'd1);
    chk("sim post data",  bus.Out0_Data, 32'h41);
    tick();

    // both full, then reset pulsed between edges
    push(1'b0, 32'h50, 4);
    push(1'b1, 32'h60, 4);
    push(1'b1, 32'h61, 4);
    @(negedge Clk);
    chk("pre-rst out0 count", 32'(bus.Out0_Count), 32'd2);
    chk("pre-rst out1 count", 32'(bus.Out1_Count), 32'd2);
    #1;
    Reset = 1'b1;
    exp0.delete();
    exp1.delete();
    #1;
    check_reset_state("midrst");
    #1;
    Reset = 1'b0;
    tick();
    push(1'b1, 32'h70, 4);
    @(negedge Clk);
    chk("fresh out1 data",  bus.Out1_Data, 32'h70);
    chk("fresh out1 count", 32'(bus.Out1_Count), 32'd1);
    chk("fresh out0 count", 32'(bus.Out0_Count), 32'd0);
    tick();
    bus.Out1_Ready = 1'b1;
    tick();
    bus.Out1_Ready = 1'b0;
    chk("final exp0 empty", 32'(exp0.size()), 32'd0);
    chk("final exp1 empty", 32'(exp1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit (required completion)");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end
endmodule

// File: doc/demux_1_to_2_fifo.md
# demux_1_to_2_fifo

Routes one 32-bit input word stream to one of two output streams, selected per word by `Sel`. It is the distribution counterpart of the 2-to-1 datapath mux: one source fans out to two consumers. Each output has its own small FIFO, so one stalled consumer does not block words bound for the other. It sits between a single producer stage and two downstream consumers, such as two write-back or memory-request paths, in the MIPS datapath.

## Interface
- `WIDTH`, default 32, data word width.
- `DEPTH`, default 2, entries per output FIFO. Must be a power of 2 and at least 2.
- `Clk`  input  1  single clock; all state updates on the rising edge.
- `Reset`  input  1  asynchronous, active-high reset.
- `In_Data`  input  WIDTH  word offered by the producer.
- `In_Sel`  input  1  destination of the offered word: 0 selects output 0, 1 selects output 1. Only meaningful while `In_Valid`=1.
- `In_Valid`  input  1  producer is offering a word.
- `In_Ready`  output  1  selected FIFO can take the offered word.
- `Out0_Data`, `Out1_Data`  output  WIDTH  head entry of each FIFO.
- `Out0_Valid`, `Out1_Valid`  output  1  that FIFO is non-empty.
- `Out0_Ready`, `Out1_Ready`  input  1  consumer takes the head entry.
- `Out0_Count`, `Out1_Count`  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Each output has its own circular FIFO: storage of DEPTH×WIDTH, write pointer, read pointer and count. Both pointers wrap modulo DEPTH.
- `In_Ready` is combinational from `In_Sel` and the selected count:
  - `In_Ready` = (count of FIFO[`In_Sel`] != DEPTH).
  - It does not depend on `Out*_Ready`. A full FIFO refuses a push even in a cycle where it is being popped; there is no pass-through.
- Push: when `In_Valid` & `In_Ready`, `In_Data` is written at the write pointer of FIFO[`In_Sel`], that write pointer increments, and count+1.
- Pop, per FIFO: when `OutN_Valid` & `OutN_Ready`, the read pointer increments and count-1.
- `OutN_Valid` = (countN != 0). `OutN_Data` = storage[read pointerN].
  - `OutN_Data` is don't-care while `OutN_Valid`=0.
  - Storage is cleared on reset, so `OutN_Data` reads 0 right after reset.
- Simultaneous push and pop on the same FIFO, not full: both take effect and the count is unchanged.
- Simultaneous pop on output 0 and push to output 1, or the reverse: the two FIFOs are independent and both take effect.
- Ordering: words reach each output in acceptance order. There is no ordering guarantee between the two outputs.
- `In_Valid`=0: `In_Sel` and `In_Data` are ignored. `In_Ready` still reflects the selected FIFO.
- `OutN_Ready` with an empty FIFO has no effect. The count never underflows.
- Producer side: the producer must hold `In_Data` and `In_Sel` stable while `In_Valid`=1 and `In_Ready`=0.
- Consumer side: the block holds `OutN_Data` stable while `OutN_Valid`=1 and the entry is not popped.

## Timing
- Reset, asynchronous, takes effect immediately and also mid-transfer:
  - All pointers and counts go to 0 and storage is cleared to 0.
  - `Out0_Valid`=`Out1_Valid`=0, `Out0_Data`=`Out1_Data`=0, `Out0_Count`=`Out1_Count`=0.
  - `In_Ready`=1 (both FIFOs are empty).
  - All contents in flight are discarded.
  - The first accepting edge is the first rising `Clk` edge after `Reset` deasserts.
- Latency: a word accepted at edge k appears on `OutN_Data` with `OutN_Valid`=1 right after edge k, provided the FIFO was empty. It can be popped at edge k+1.
- Throughput: one push per cycle into either FIFO, plus one pop per cycle per output.
  - Holding `OutN_Ready`=1 with a steady input sustains one word per cycle through output N.
  - DEPTH=2 keeps the full-refuse rule from creating bubbles in this case.
- Counts update on the edge of the push or pop.
- `In_Ready` changes combinationally when `In_Sel` changes.

## Test plan
- Reset and basic routing:
  - Stimulus: reset, then push 0xAAAA0001 with Sel=0, then 0xBBBB0002 with Sel=1, with both Ready held 0.
  - Required: Out0_Data=0xAAAA0001 and Out1_Data=0xBBBB0002, both Valid=1, both Count=1.
- Fill and refuse:
  - Stimulus: push 3 words 0x10, 0x11, 0x12 with Sel=0 while Out0_Ready=0.
  - Required: In_Ready drops to 0 after 2 accepts and Out0_Count=2. The third word is held until one pop, then accepted. Output order is 0x10, 0x11, 0x12.
- Independence:
  - Stimulus: FIFO0 full and stalled, then push 0x20 with Sel=1.
  - Required: In_Ready=1 with Sel=1 and In_Ready=0 with Sel=0. 0x20 is accepted and Out1_Valid=1 after the edge.
- Streaming with wrap-around:
  - Stimulus: 8 consecutive words 0x30–0x37 with Sel=1 and Out1_Ready=1 throughout.
  - Required: one word per cycle. Out1 shows 0x30–0x37 in order, each one cycle after acceptance, and Out1_Count never exceeds 1.
- Simultaneous push and pop:
  - Stimulus: Out0_Count=1 (head 0x40); push 0x41 with Sel=0 while Out0_Ready=1.
  - Required: after the edge, Out0_Count=1 and Out0_Data=0x41.
- Reset mid-operation:
  - Stimulus: both FIFOs full; pulse Reset between clock edges.
  - Required: immediately, both Valid=0, both Count=0 and In_Ready=1. After reset deasserts, the next push behaves as on a fresh start.
